pdm_buffer_writer: RTL and testbench

- Fills the flat PDM sample buffer that the PDM output multiplexer reads by sample index.
- Accepts 64-bit PDM words on an AXI-Stream-style slave port and writes them to consecutive buffer entries, starting at entry 0.
- Loads a host-programmed number of entries, then signals completion.
- Sits between the DMA/AXI stream from the PS and the PDM multiplexer input.

---
 rtl/pdm_pkg.sv | 15 +
 rtl/pdm_buffer_writer.sv | 145 ++++++++++++++
 tb/tb_pdm_buffer_writer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and state type for the PDM sample buffer writer.
package pdm_pkg;

   localparam int unsigned PDM_BUFFER_WIDTH_DEF        = 128;
   localparam int unsigned PDM_DATA_WIDTH_DEF          = 64;
   localparam int unsigned PDM_BUFFER_ADRESS_WIDTH_DEF = 7;
   localparam int unsigned PDM_LEN_WIDTH_DEF           = PDM_BUFFER_ADRESS_WIDTH_DEF + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } pdm_wr_state_e;

endpackage

// File: rtl/pdm_buffer_writer.sv
// Loads AXI-Stream PDM words into consecutive entries of a flat sample buffer.
// Optional tlast framing check enabled by defining PDM_BUFFER_WRITER_TLAST_CHECK_EN.
module pdm_buffer_writer
   import pdm_pkg::*;
#(
   parameter int unsigned PDM_BUFFER_WIDTH        = PDM_BUFFER_WIDTH_DEF,
   parameter int unsigned PDM_DATA_WIDTH          = PDM_DATA_WIDTH_DEF,
   parameter int unsigned PDM_BUFFER_ADRESS_WIDTH = PDM_BUFFER_ADRESS_WIDTH_DEF
) (
   input  logic                                     clk,
   input  logic                                     aresetn,
   input  logic                                     start,
   input  logic [PDM_BUFFER_ADRESS_WIDTH:0]         load_length,
   input  logic [PDM_DATA_WIDTH-1:0]                s_axis_tdata,
   input  logic                                     s_axis_tvalid,
   output logic                                     s_axis_tready,
   input  logic                                     s_axis_tlast,
   output logic [PDM_BUFFER_WIDTH*PDM_DATA_WIDTH-1:0] pdm_data_out,
   output logic [PDM_BUFFER_ADRESS_WIDTH:0]         wr_count,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     frame_err
);

   localparam int unsigned LenW = PDM_BUFFER_ADRESS_WIDTH + 1;
   localparam int unsigned PtrW = PDM_BUFFER_ADRESS_WIDTH;

   pdm_wr_state_e          state_q;
   logic [LenW-1:0]        len_q;
   logic [LenW-1:0]        wr_count_q;
   logic [PtrW-1:0]        wr_ptr_q;
   logic                   tready_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   beat;
   logic                   start_acc;
   logic                   last_beat;
   logic [LenW-1:0]        cnt_inc;
   logic [LenW-1:0]        len_clamped;
   logic [PDM_BUFFER_WIDTH-1:0] wr_en;

   assign beat      = s_axis_tvalid && tready_q;
   assign start_acc = start && (state_q == IDLE);
   assign cnt_inc   = wr_count_q + LenW'(1);
   assign last_beat = (cnt_inc == len_q);

   // Zero or oversize requests load the whole buffer.
   assign len_clamped = ((load_length == '0) || (load_length > LenW'(PDM_BUFFER_WIDTH)))
                        ? LenW'(PDM_BUFFER_WIDTH) : load_length;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wr_count_q <= '0;
         wr_ptr_q   <= '0;
         tready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  len_q      <= len_clamped;
                  wr_count_q <= '0;
                  wr_ptr_q   <= '0;
                  tready_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               if (beat) begin
                  wr_ptr_q   <= wr_ptr_q + PtrW'(1);
                  wr_count_q <= cnt_inc;
                  if (last_beat) begin
                     tready_q <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               tready_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   // Per-entry decoded write enable; each entry is its own register.
   for (genvar i = 0; i < PDM_BUFFER_WIDTH; i++) begin : g_entry
      logic [PDM_DATA_WIDTH-1:0] entry_q;

      assign wr_en[i] = beat && (wr_ptr_q == PtrW'(i));

      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            entry_q <= '0;
         end else if (wr_en[i]) begin
            entry_q <= s_axis_tdata;
         end
      end

      assign pdm_data_out[i*PDM_DATA_WIDTH +: PDM_DATA_WIDTH] = entry_q;
   end

`ifdef PDM_BUFFER_WRITER_TLAST_CHECK_EN
   logic frame_err_q;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         frame_err_q <= 1'b0;
      end else if (start_acc) begin
         frame_err_q <= 1'b0;
      end else if (beat && (s_axis_tlast != last_beat)) begin
         frame_err_q <= 1'b1;
      end
   end

   assign frame_err = frame_err_q;
`else
   logic unused_tlast;
   logic unused_start_acc;

   assign unused_tlast     = s_axis_tlast;
   assign unused_start_acc = start_acc;
   assign frame_err        = 1'b0;
`endif

   assign s_axis_tready = tready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_pdm_buffer_writer.sv
// Directed bench for pdm_buffer_writer with hand-computed expectations.
module tb_pdm_buffer_writer;

   localparam int unsigned BW = 128;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 7;

   logic              clk;
   logic              aresetn;
   logic              start;
   logic [AW:0]       load_length;
   logic [DW-1:0]     s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tlast;
   logic [BW*DW-1:0]  pdm_data_out;
   logic [AW:0]       wr_count;
   logic              busy;
   logic              done;
   logic              frame_err;

   int tests;
   int fails;
   int n;
   logic fe_exp;

   pdm_buffer_writer dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .start         (start),
      .load_length   (load_length),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .pdm_data_out  (pdm_data_out),
      .wr_count      (wr_count),
      .busy          (busy),
      .done          (done),
      .frame_err     (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] entry(input int i);
      return pdm_data_out[i*DW +: DW];
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      aresetn       = 1'b0;
      start         = 1'b0;
      load_length   = '0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
`ifdef PDM_BUFFER_WRITER_TLAST_CHECK_EN
      fe_exp = 1'b1;
`else
      fe_exp = 1'b0;
`endif
      #22;
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wr_count", 64'(wr_count), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_entry0", entry(0), 64'd0);
      check("rst_entry127", entry(127), 64'd0);
      aresetn = 1'b1;
      tick();

      // Load 4 entries with tvalid held high.
      start = 1'b1; load_length = 8'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t1_tready", 64'(s_axis_tready), 64'd1);
         check("t1_busy", 64'(busy), 64'd1);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'hA0 + 64'(i);
         tick();
      end
      s_axis_tvalid = 1'b0;
      check("t1_done", 64'(done), 64'd1);
      check("t1_tready_done", 64'(s_axis_tready), 64'd0);
      check("t1_busy_done", 64'(busy), 64'd0);
      check("t1_wr_count", 64'(wr_count), 64'd4);
      for (int i = 0; i < 4; i++) check("t1_entry", entry(i), 64'hA0 + 64'(i));
      check("t1_entry4", entry(4), 64'd0);
      tick();
      check("t1_done_pulse", 64'(done), 64'd0);

      // Beats in IDLE without start are refused.
      s_axis_tvalid = 1'b1; s_axis_tdata = 64'hDEAD;
      for (int i = 0; i < 3; i++) begin
         check("idle_tready", 64'(s_axis_tready), 64'd0);
         tick();
      end
      s_axis_tvalid = 1'b0;
      check("idle_entry0", entry(0), 64'hA0);
      check("idle_entry4", entry(4), 64'd0);
      check("idle_wr_count", 64'(wr_count), 64'd4);

      // Length 0 clamps to the full buffer.
      start = 1'b1; load_length = 8'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'(i) * 64'h0101;
         tick();
         if (i == 126) check("t2_busy_before_last", 64'(busy), 64'd1);
      end
      s_axis_tvalid = 1'b0;
      check("t2_done", 64'(done), 64'd1);
      check("t2_wr_count", 64'(wr_count), 64'd128);
      for (int i = 0; i < 128; i++) check("t2_entry", entry(i), 64'(i) * 64'h0101);
      tick();

      // Length 8, tvalid toggling, a start mid-load must be ignored.
      start = 1'b1; load_length = 8'd8;
      tick();
      start = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         check("t3_busy", 64'(busy), 64'd1);
         s_axis_tvalid = cyc[0];
         s_axis_tdata  = 64'hB0 + 64'(n);
         start         = (cyc == 5);
         load_length   = (cyc == 5) ? 8'd2 : 8'd8;
         tick();
         if (s_axis_tvalid) n++;
         if (n == 8) break;
      end
      check("t3_beats_in_budget", 64'(n), 64'd8);
      s_axis_tvalid = 1'b0; start = 1'b0;
      check("t3_done", 64'(done), 64'd1);
      check("t3_wr_count", 64'(wr_count), 64'd8);
      for (int i = 0; i < 8; i++) check("t3_entry", entry(i), 64'hB0 + 64'(i));
      check("t3_entry8_kept", entry(8), 64'h0808);
      tick();
      check("t3_done_pulse", 64'(done), 64'd0);

      // Reset mid-load clears everything at once.
      start = 1'b1; load_length = 8'd6;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'hC0 + 64'(i);
         tick();
      end
      s_axis_tvalid = 1'b0;
      check("t4_pre_entry2", entry(2), 64'hC2);
      #2;
      aresetn = 1'b0;
      #1;
      check("t4_rst_tready", 64'(s_axis_tready), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      check("t4_rst_wr_count", 64'(wr_count), 64'd0);
      check("t4_rst_entry0", entry(0), 64'd0);
      check("t4_rst_entry2", entry(2), 64'd0);
      check("t4_rst_entry7", entry(7), 64'd0);
      check("t4_rst_entry127", entry(127), 64'd0);
      #1;
      aresetn = 1'b1;
      tick();
      start = 1'b1; load_length = 8'd2;
      tick();
      start = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tdata = 64'hD0;
      tick();
      s_axis_tdata = 64'hD1;
      tick();
      s_axis_tvalid = 1'b0;
      check("t4_done", 64'(done), 64'd1);
      check("t4_entry0", entry(0), 64'hD0);
      check("t4_entry1", entry(1), 64'hD1);
      check("t4_entry2", entry(2), 64'd0);
      tick();

      // tlast on beat 2 of 4 flags a framing error (only with the check enabled).
      start = 1'b1; load_length = 8'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'hE0 + 64'(i);
         s_axis_tlast  = (i == 1) || (i == 3);
         tick();
         if (i == 0) check("t5_fe_beat1", 64'(frame_err), 64'd0);
         if (i == 1) check("t5_fe_beat2", 64'(frame_err), 64'(fe_exp));
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      check("t5_done", 64'(done), 64'd1);
      check("t5_wr_count", 64'(wr_count), 64'd4);
      check("t5_fe_at_done", 64'(frame_err), 64'(fe_exp));
      tick();
      check("t5_fe_sticky", 64'(frame_err), 64'(fe_exp));
      start = 1'b1; load_length = 8'd1;
      tick();
      start = 1'b0;
      check("t5_fe_cleared", 64'(frame_err), 64'd0);
      s_axis_tvalid = 1'b1; s_axis_tdata = 64'hF0; s_axis_tlast = 1'b1;
      tick();
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      check("t5_done_len1", 64'(done), 64'd1);
      check("t5_fe_clean_frame", 64'(frame_err), 64'd0);
      check("t5_entry0", entry(0), 64'hF0);
      check("t5_entry1", entry(1), 64'hE1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
